// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-master unified RAM arbiter.
// Imported by rr_pick2 and mem_arbiter.
package mem_arbiter_pkg;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int RDATA_W = 32;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } arb_state_t;

   typedef logic mid_t;
   localparam mid_t M0 = 1'b0;
   localparam mid_t M1 = 1'b1;

   // Saturating increment used by the optional access statistics
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// rr_pick2: combinational two-way picker; the last-grant pointer lives in mem_arbiter.
// A lone requester always wins; ties go round-robin or to m0 when FIXED_PRI is set.
module rr_pick2
   import mem_arbiter_pkg::*;
#(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic [1:0] req,
   input  mid_t       last,
   output mid_t       win,
   output logic       valid
);

   always_comb begin
      valid = |req;
      win   = M0;
      if (req == 2'b10) begin
         win = M1;
      end else if (req == 2'b11 && !FIXED_PRI && last == M0) begin
         win = M1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified RAM between the ktc16 core (m0) and a secondary master (m1).
// Optional MEM_ARBITER_STATS_EN adds saturating grant and conflict counters.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW        = ADDR_W,
   parameter int DW        = DATA_W,
   parameter int RW        = RDATA_W,
   parameter int FIXED_PRI = 0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wd,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [RW-1:0] m0_rd,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wd,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [RW-1:0] m1_rd,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wd,
   input  logic [RW-1:0] ram_rd
`ifdef MEM_ARBITER_STATS_EN
   ,
   output logic [15:0]   stat_m0_cnt,
   output logic [15:0]   stat_m1_cnt,
   output logic [15:0]   stat_conflict_cnt
`endif
);

   arb_state_t    state;
   mid_t          lat_id;
   mid_t          last;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wd;

   mid_t          pick_id;
   logic          pick_valid;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wd;

   rr_pick2 #(
      .FIXED_PRI (FIXED_PRI != 0)
   ) u_pick (
      .req   ({m1_req, m0_req}),
      .last  (last),
      .win   (pick_id),
      .valid (pick_valid)
   );

   assign sel_we   = (pick_id == M1) ? m1_we   : m0_we;
   assign sel_addr = (pick_id == M1) ? m1_addr : m0_addr;
   assign sel_wd   = (pick_id == M1) ? m1_wd   : m0_wd;

   // Address/data always show the latched access; the strobe is gated by reset so an aborted write never lands
   assign ram_addr = lat_addr;
   assign ram_wd   = lat_wd;
   assign ram_we   = (state == ISSUE) && lat_we && !reset;

   // Access sequencer: arbitrate in IDLE/RESP, drive the RAM in ISSUE, return read data in RESP
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last      <= M1;
         lat_id    <= M0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wd    <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rd     <= '0;
         m1_rd     <= '0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         case (state)
            ISSUE: begin
               if (lat_we) begin
                  state <= IDLE;
               end else begin
                  state <= RESP;
                  if (lat_id == M1) begin
                     m1_rd     <= ram_rd;
                     m1_rvalid <= 1'b1;
                  end else begin
                     m0_rd     <= ram_rd;
                     m0_rvalid <= 1'b1;
                  end
               end
            end
            default: begin
               if (pick_valid) begin
                  state    <= ISSUE;
                  lat_id   <= pick_id;
                  lat_we   <= sel_we;
                  lat_addr <= sel_addr;
                  lat_wd   <= sel_wd;
                  last     <= pick_id;
                  m0_gnt   <= (pick_id == M0);
                  m1_gnt   <= (pick_id == M1);
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef MEM_ARBITER_STATS_EN
   logic arb_slot;
   assign arb_slot = (state == IDLE) || (state == RESP);

   // Grants are counted in their ISSUE cycle; conflicts only in cycles where arbitration actually runs
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_m0_cnt       <= '0;
         stat_m1_cnt       <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (m0_gnt) begin
            stat_m0_cnt <= sat_inc(stat_m0_cnt);
         end
         if (m1_gnt) begin
            stat_m1_cnt <= sat_inc(stat_m1_cnt);
         end
         if (arb_slot && m0_req && m1_req) begin
            stat_conflict_cnt <= sat_inc(stat_conflict_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts grants and read data,
// a negedge monitor compares; a second FIXED_PRI=1 instance checks strict m0 priority.
module tb_mem_arbiter;

   localparam int FIXED_PRI = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [15:0] m0_addr, m0_wd, m1_addr, m1_wd;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rd, m1_rd;
   logic        ram_we;
   logic [15:0] ram_addr, ram_wd;
   logic [31:0] ram_rd;

   logic        fx_m0_req, fx_m1_req;
   logic        fx_m0_gnt, fx_m0_rvalid, fx_m1_gnt, fx_m1_rvalid;
   logic [31:0] fx_m0_rd, fx_m1_rd;
   logic        fx_ram_we;
   logic [15:0] fx_ram_addr, fx_ram_wd;

`ifdef MEM_ARBITER_STATS_EN
   logic [15:0] stat_m0_cnt, stat_m1_cnt, stat_conflict_cnt;
   logic [15:0] fx_stat_m0, fx_stat_m1, fx_stat_conf;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.FIXED_PRI(FIXED_PRI)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
`ifdef MEM_ARBITER_STATS_EN
      , .stat_m0_cnt(stat_m0_cnt), .stat_m1_cnt(stat_m1_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
   );

   mem_arbiter #(.FIXED_PRI(1)) fix (
      .clk(clk), .reset(reset),
      .m0_req(fx_m0_req), .m0_we(1'b0), .m0_addr(16'h0060), .m0_wd(16'h0000),
      .m0_gnt(fx_m0_gnt), .m0_rvalid(fx_m0_rvalid), .m0_rd(fx_m0_rd),
      .m1_req(fx_m1_req), .m1_we(1'b0), .m1_addr(16'h0061), .m1_wd(16'h0000),
      .m1_gnt(fx_m1_gnt), .m1_rvalid(fx_m1_rvalid), .m1_rd(fx_m1_rd),
      .ram_we(fx_ram_we), .ram_addr(fx_ram_addr), .ram_wd(fx_ram_wd), .ram_rd(32'h1234_5678)
`ifdef MEM_ARBITER_STATS_EN
      , .stat_m0_cnt(fx_stat_m0), .stat_m1_cnt(fx_stat_m1), .stat_conflict_cnt(fx_stat_conf)
`endif
   );

   // RAM: combinational read, write of the low half at the posedge
   logic [31:0] mem [0:255];
   assign ram_rd = mem[ram_addr[7:0]];
   initial forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr[7:0]][15:0] <= ram_wd;
   end

   typedef struct { int cyc; logic [15:0] addr; logic we; logic [15:0] wd; } gnt_exp_t;
   typedef struct { int cyc; logic [31:0] data; } rd_exp_t;
   gnt_exp_t gq0[$], gq1[$];
   rd_exp_t  rq0[$], rq1[$];

   // Reference model: one decision per free slot, each decision blocks arbitration for the next cycle
   logic [31:0] sh [0:255];
   int          cyc = 0;
   int          next_arb = 0;
   int          last_m = 1;
   int          mdl_cnt0 = 0, mdl_cnt1 = 0, mdl_conf = 0;
   bit          model_en = 1'b1;
   int          w;
   logic        mw;
   logic [15:0] ma, md;

   initial forever begin
      @(posedge clk);
      if (reset) begin
         last_m   = 1;
         next_arb = cyc + 1;
         mdl_cnt0 = 0; mdl_cnt1 = 0; mdl_conf = 0;
      end else if (model_en && cyc >= next_arb && (m0_req || m1_req)) begin
         if (m0_req && m1_req) begin
            mdl_conf++;
            w = (FIXED_PRI != 0) ? 0 : ((last_m == 1) ? 0 : 1);
         end else begin
            w = m1_req ? 1 : 0;
         end
         mw = (w == 1) ? m1_we   : m0_we;
         ma = (w == 1) ? m1_addr : m0_addr;
         md = (w == 1) ? m1_wd   : m0_wd;
         if (w == 1) begin gq1.push_back('{cyc + 1, ma, mw, md}); mdl_cnt1++; end
         else        begin gq0.push_back('{cyc + 1, ma, mw, md}); mdl_cnt0++; end
         if (mw) sh[ma[7:0]][15:0] = md;
         else if (w == 1) rq1.push_back('{cyc + 2, sh[ma[7:0]]});
         else             rq0.push_back('{cyc + 2, sh[ma[7:0]]});
         last_m   = w;
         next_arb = cyc + 2;
      end
      cyc++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic checkGnt(input int m);
      gnt_exp_t e;
      if ((m == 0 && gq0.size() == 0) || (m == 1 && gq1.size() == 0)) begin
         total++; bad++;
         $display("[TB] FAIL unexpected_gnt%0d at cycle %0d: got gnt, want none", m, cyc);
      end else begin
         e = (m == 0) ? gq0.pop_front() : gq1.pop_front();
         checkOutput($sformatf("gnt%0d_cycle", m), 32'(cyc), 32'(e.cyc));
         checkOutput($sformatf("gnt%0d_addr", m), 32'(ram_addr), 32'(e.addr));
         checkOutput($sformatf("gnt%0d_we", m), 32'(ram_we), 32'(e.we));
         if (e.we) checkOutput($sformatf("gnt%0d_wd", m), 32'(ram_wd), 32'(e.wd));
      end
   endtask

   task automatic checkRd(input int m, input logic [31:0] rd);
      rd_exp_t e;
      if ((m == 0 && rq0.size() == 0) || (m == 1 && rq1.size() == 0)) begin
         total++; bad++;
         $display("[TB] FAIL unexpected_rvalid%0d at cycle %0d: got rvalid, want none", m, cyc);
      end else begin
         e = (m == 0) ? rq0.pop_front() : rq1.pop_front();
         checkOutput($sformatf("rvalid%0d_cycle", m), 32'(cyc), 32'(e.cyc));
         checkOutput($sformatf("rd%0d_data", m), rd, e.data);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a gnt or rvalid
   initial forever begin
      @(negedge clk);
      if (model_en && !reset) begin
         if (m0_gnt)    checkGnt(0);
         if (m1_gnt)    checkGnt(1);
         if (m0_rvalid) checkRd(0, m0_rd);
         if (m1_rvalid) checkRd(1, m1_rd);
         if (ram_we && !m0_gnt && !m1_gnt) checkOutput("stray_ram_we", 32'(ram_we), 32'h0);
         if (gq0.size() > 0 && gq0[0].cyc < cyc) begin void'(gq0.pop_front()); checkOutput("missing_gnt0", 32'h0, 32'h1); end
         if (gq1.size() > 0 && gq1[0].cyc < cyc) begin void'(gq1.pop_front()); checkOutput("missing_gnt1", 32'h0, 32'h1); end
         if (rq0.size() > 0 && rq0[0].cyc < cyc) begin void'(rq0.pop_front()); checkOutput("missing_rvalid0", 32'h0, 32'h1); end
         if (rq1.size() > 0 && rq1[0].cyc < cyc) begin void'(rq1.pop_front()); checkOutput("missing_rvalid1", 32'h0, 32'h1); end
      end
   end

   // Issue one access from master m and hold it until granted (bounded wait)
   task automatic applyStimulus(input int m, input logic we, input logic [15:0] a, input logic [15:0] d);
      bit got = 1'b0;
      @(negedge clk);
      if (m == 0) begin m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wd = d; end
      else        begin m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wd = d; end
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         got = (m == 0) ? m0_gnt : m1_gnt;
      end
      if (m == 0) begin m0_req = 1'b0; m0_we = 1'b0; end
      else        begin m1_req = 1'b0; m1_we = 1'b0; end
      if (!got) begin
         total++; bad++;
         $display("[TB] FAIL gnt_timeout%0d: got no gnt in 40 cycles, want gnt", m);
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   int g0, g1, rv0, rv1, fwe;

   initial begin
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
      fx_m0_req = 1'b0; fx_m1_req = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = {16'hC0DE, 16'(i)};
         sh[i]  = {16'hC0DE, 16'(i)};
      end
      mem[8'h54] = 32'hDEAD_BEEF;
      sh[8'h54]  = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk);
      $display("[TB] reset values");
      checkOutput("rst_m0_gnt", 32'(m0_gnt), 32'h0);
      checkOutput("rst_m1_gnt", 32'(m1_gnt), 32'h0);
      checkOutput("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
      checkOutput("rst_m1_rvalid", 32'(m1_rvalid), 32'h0);
      checkOutput("rst_ram_we", 32'(ram_we), 32'h0);
      checkOutput("rst_ram_addr", 32'(ram_addr), 32'h0);
      checkOutput("rst_ram_wd", 32'(ram_wd), 32'h0);
      checkOutput("rst_m0_rd", m0_rd, 32'h0);
      checkOutput("rst_m1_rd", m1_rd, 32'h0);
      reset = 1'b0;

      $display("[TB] directed write/read");
      applyStimulus(0, 1'b1, 16'h0050, 16'h0007);
      repeat (3) @(negedge clk);
      applyStimulus(0, 1'b0, 16'h0050, 16'h0000);
      repeat (3) @(negedge clk);
      checkOutput("m0_rd_readback", m0_rd, 32'hC0DE_0007);
      applyStimulus(1, 1'b0, 16'h0054, 16'h0000);
      repeat (3) @(negedge clk);
      checkOutput("m1_rd_beef", m1_rd, 32'hDEAD_BEEF);
      checkOutput("m0_rd_untouched", m0_rd, 32'hC0DE_0007);
      repeat (5) @(negedge clk);
      checkOutput("m1_rd_held", m1_rd, 32'hDEAD_BEEF);

      $display("[TB] continuous contention");
      fork
         repeat (4) applyStimulus(0, 1'b0, 16'h0051, 16'h0000);
         repeat (4) applyStimulus(1, 1'b0, 16'h0052, 16'h0000);
      join
      repeat (4) @(negedge clk);

      $display("[TB] fixed priority instance");
      fx_m0_req = 1'b1; fx_m1_req = 1'b1;
      repeat (3) @(negedge clk);
      g0 = 0; g1 = 0; rv0 = 0; rv1 = 0; fwe = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         g0 += int'(fx_m0_gnt); g1 += int'(fx_m1_gnt);
         rv0 += int'(fx_m0_rvalid); rv1 += int'(fx_m1_rvalid); fwe += int'(fx_ram_we);
      end
      checkOutput("fix_m0_gnts", 32'(g0), 32'd10);
      checkOutput("fix_m1_gnts", 32'(g1), 32'd0);
      checkOutput("fix_m0_rvalids", 32'(rv0), 32'd10);
      checkOutput("fix_m1_rvalids", 32'(rv1), 32'd0);
      checkOutput("fix_ram_we", 32'(fwe), 32'd0);
      checkOutput("fix_m0_rd", fx_m0_rd, 32'h1234_5678);
      checkOutput("fix_m1_rd", fx_m1_rd, 32'h0);
      checkOutput("fix_ram_addr", 32'(fx_ram_addr), 32'h0060);
      checkOutput("fix_ram_wd", 32'(fx_ram_wd), 32'h0);
      fx_m0_req = 1'b0; fx_m1_req = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] reset during write issue");
      model_en = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 16'h005A; m0_wd = 16'hABCD;
      g0 = 0;
      for (int n = 0; n < 40 && g0 == 0; n++) begin
         @(negedge clk);
         g0 = int'(m0_gnt);
      end
      checkOutput("rst_abort_gnt_seen", 32'(g0), 32'h1);
      reset = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0;
      #1;
      checkOutput("rst_abort_ram_we", 32'(ram_we), 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_abort_mem", mem[8'h5A], 32'hC0DE_005A);
      checkOutput("rst_abort_m0_gnt", 32'(m0_gnt), 32'h0);
      checkOutput("rst_abort_m1_gnt", 32'(m1_gnt), 32'h0);
      checkOutput("rst_abort_m0_rvalid", 32'(m0_rvalid), 32'h0);
      checkOutput("rst_abort_m1_rvalid", 32'(m1_rvalid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      model_en = 1'b1;
      applyStimulus(0, 1'b0, 16'h005A, 16'h0000);
      repeat (3) @(negedge clk);

      $display("[TB] random traffic");
      fork
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(0, 1'($urandom_range(0, 1)), 16'h0050 + 16'($urandom_range(0, 15)), 16'($urandom));
         end
         for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(1, 1'($urandom_range(0, 1)), 16'h0050 + 16'($urandom_range(0, 15)), 16'($urandom));
         end
      join
      repeat (10) @(negedge clk);

      checkOutput("gq0_drained", 32'(gq0.size()), 32'h0);
      checkOutput("gq1_drained", 32'(gq1.size()), 32'h0);
      checkOutput("rq0_drained", 32'(rq0.size()), 32'h0);
      checkOutput("rq1_drained", 32'(rq1.size()), 32'h0);
`ifdef MEM_ARBITER_STATS_EN
      checkOutput("stat_m0", 32'(stat_m0_cnt), 32'(mdl_cnt0));
      checkOutput("stat_m1", 32'(stat_m1_cnt), 32'(mdl_cnt1));
      checkOutput("stat_conflict", 32'(stat_conflict_cnt), 32'(mdl_conf));
      checkOutput("fix_stat_m0", 32'(fx_stat_m0), 32'h0);
      checkOutput("fix_stat_m1", 32'(fx_stat_m1), 32'h0);
      checkOutput("fix_stat_conf", 32'(fx_stat_conf), 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
